key_event_arbiter: RTL and testbench
====================================

Name: key_event_arbiter

Overview:
Collects one-cycle short-press (`key_first`) and long-press (`key_long`) strobes from N_KEYS per-key debounce/press-classifier instances and serialises them into a single event stream.
- Each key has one pending latch per event type.
- A round-robin arbiter chooses one event per cycle.
- Chosen events go into a small FIFO, drained by a valid/ready consumer (menu/mode controller).
- Lost events are flagged, never silently dropped.

Parameters:
- N_KEYS, 4, number of key channels (2..16).
- FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2.
- KW, $clog2(N_KEYS), derived key-index width; not overridable.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- key_first  in  N_KEYS  short-press strobes, one cycle each, bit i = key i.
- key_long  in  N_KEYS  long-press strobes, one cycle each.
- ev_valid  out  1  FIFO head event available.
- ev_ready  in  1  consumer accepts head when ev_valid && ev_ready.
- ev_key  out  KW  key index of head event.
- ev_long  out  1  1 = long press, 0 = short press.
- pending  out  N_KEYS  bit i = key i has any pending, not-yet-queued event.
- overflow  out  1  sticky lost-event flag.
- clr_overflow  in  1  clears overflow.

Interface fixed: one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset (async assert, any time incl. mid-transfer):
  - All pending latches 0; FIFO empty; round-robin pointer = N_KEYS-1, so key 0 is searched first.
  - ev_valid=0, ev_key=0, ev_long=0, pending=0, overflow=0.
  - Queued and pending events are discarded.
- Pending latches pf[i] and pl[i]:
  - Set on the strobe. A strobe in cycle t is visible in pending at t+1.
  - Cleared in the cycle the latch is granted into the FIFO.
  - Strobe arriving in the same cycle its own latch is granted: latch stays set, the new event is kept.
  - Strobe arriving while its latch is set and not granted that cycle: event lost, overflow <= 1.
  - key_first[i] and key_long[i] in the same cycle: both latched independently.
- Arbiter, evaluated on registered latch state:
  - req[i] = pf[i] | pl[i].
  - A grant happens only when FIFO count < FIFO_DEPTH, using the registered count; a read in the same cycle does not free a slot for that cycle's grant.
  - Search order starts at pointer+1, wrapping modulo N_KEYS. The first requesting key wins, and the pointer is set to the winner.
  - Within the winning key, long has priority over first. Exactly one event per cycle.
  - FIFO full: no grant, and latches hold their state.
- FIFO:
  - Write on grant with entry {key index, long}. Read on ev_valid && ev_ready.
  - Simultaneous read and write: count unchanged.
  - Show-ahead: ev_key/ev_long reflect the head. Both hold stable while ev_valid && !ev_ready.
  - Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- Latency: strobe at t, pending at t+1, written at the end of t+1, ev_valid=1 at t+2 when the FIFO was empty and not blocked.
- ev_ready while !ev_valid: ignored.
- overflow: sticky. clr_overflow clears it; a loss event in the same cycle wins, so overflow stays 1.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Package key_pkg:
  - typedef key_ev_t packed struct {logic long; logic [KW-1:0] idx}.
  - Constants KEY_EV_SHORT=1'b0 and KEY_EV_LONG=1'b1.
  - Default N_KEYS and FIFO_DEPTH localparams.
- One sub-module: key_event_fifo.
  - Parameterised depth and key_ev_t payload, show-ahead.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, empty, full, count.
- Pending latches and the round-robin arbiter stay in the top module.

Test Plan (N_KEYS=4, FIFO_DEPTH=8):
1. After reset, pulse key_first[2] at cycle 10 -> pending=4'b0100 at 11; ev_valid=1, ev_key=2, ev_long=0 at 12; ev_ready=1 at 12 -> ev_valid=0 at 13.
2. ev_ready=0; pulse key_first=4'b1111 in one cycle -> FIFO order: keys 0,1,2,3. Repeat after drain -> order continues 0,1,2,3 (pointer wrapped from 3).
3. Same cycle key_first[1]=1, key_long[1]=1 -> two events, (1,long=1) first, then (1,long=0); overflow stays 0.
4. ev_ready=0; queue 8 events, then 4 more strobes on keys 0..3 -> FIFO holds 8, pending=4'b1111. Pulse key_first[0] again -> overflow=1. Set ev_ready=1 -> queued events drain; each freed slot is refilled on the next cycle, no duplicates. clr_overflow -> overflow=0.
5. clr_overflow and a loss event in the same cycle -> overflow remains 1.
6. Assert rst mid-stream with 3 queued and 2 pending -> ev_valid, pending, overflow, ev_key and ev_long immediately 0. After release, the first strobe on key 3 appears as ev_key=3 two cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the key event arbiter.
//   key_ev_t : one queued event, {long, idx}
//   KEY_EV_SHORT / KEY_EV_LONG : encodings of the long field
package key_pkg;

  localparam int unsigned N_KEYS_DEFAULT     = 4;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

  // Index field is sized for the largest supported key count (16); the top
  // narrows it to its own KW on the way out.
  localparam int unsigned KEY_IDX_W = 4;

  localparam logic KEY_EV_SHORT = 1'b0;
  localparam logic KEY_EV_LONG  = 1'b1;

  typedef struct packed {
    logic                 long;
    logic [KEY_IDX_W-1:0] idx;
  } key_ev_t;

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead FIFO of key events.
//   clk, rst  : clock, async active-high reset (empties the FIFO)
//   wr_en     : push wr_data (ignored when full)
//   rd_en     : pop head (ignored when empty)
//   rd_data   : head entry, zero while empty
//   empty/full/count : occupancy, all derived from registered state
module key_event_fifo
  import key_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  key_ev_t       wr_data,
  input  logic          rd_en,
  output key_ev_t       rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  key_ev_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Forced to zero when empty so stale entries never show on the outputs.
  assign rd_data = empty ? key_ev_t'('0) : mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
      else if (!do_wr && do_rd) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Serialises per-key short/long press strobes into one event stream.
//   key_first / key_long : one-cycle strobes per key
//   ev_valid/ev_ready    : valid/ready handshake on the FIFO head
//   ev_key / ev_long     : head event (key index, long=1 / short=0)
//   pending              : key has a latched event not yet queued
//   overflow             : sticky lost-event flag, cleared by clr_overflow
module key_event_arbiter
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS     = N_KEYS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int unsigned KW        = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_first,
  input  logic [N_KEYS-1:0] key_long,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [KW-1:0]     ev_key,
  output logic              ev_long,
  output logic [N_KEYS-1:0] pending,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [N_KEYS-1:0] pf_q, pl_q, pf_d, pl_d;
  logic [N_KEYS-1:0] req, gnt_onehot, clr_f, clr_l;
  logic [KW-1:0]     rr_q, gnt_idx;
  logic              gnt_found, gnt_long, do_grant, lost, overflow_q;
  logic              fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;
  key_ev_t           wr_ev, rd_ev;

  function automatic logic [KW-1:0] rr_plus(input logic [KW-1:0] base, input int unsigned off);
    return KW'((32'(base) + off) % N_KEYS);
  endfunction

  // Round-robin search starting one past the last winner.
  always_comb begin
    req       = pf_q | pl_q;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 1; k <= N_KEYS; k++) begin
      if (!gnt_found && req[rr_plus(rr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_plus(rr_q, k);
      end
    end
    // Full is taken from the registered count, so a same-cycle pop never
    // opens a slot for this cycle's grant.
    do_grant = gnt_found && !fifo_full;
    gnt_long = pl_q[gnt_idx];
  end

  // Latch update: a strobe on the latch being granted re-arms it; a strobe on
  // a set latch that is not granted is a lost event.
  always_comb begin
    gnt_onehot = '0;
    if (do_grant) gnt_onehot[gnt_idx] = 1'b1;
    clr_f = gnt_onehot & {N_KEYS{!gnt_long}};
    clr_l = gnt_onehot & {N_KEYS{gnt_long}};
    pf_d  = key_first | (pf_q & ~clr_f);
    pl_d  = key_long  | (pl_q & ~clr_l);
    lost  = (|(key_first & pf_q & ~clr_f)) | (|(key_long & pl_q & ~clr_l));
  end

  always_comb begin
    wr_ev.long = gnt_long ? KEY_EV_LONG : KEY_EV_SHORT;
    wr_ev.idx  = KEY_IDX_W'(gnt_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_q       <= '0;
      pl_q       <= '0;
      rr_q       <= KW'(N_KEYS - 1);
      overflow_q <= 1'b0;
    end else begin
      pf_q <= pf_d;
      pl_q <= pl_d;
      if (do_grant) rr_q <= gnt_idx;
      if (lost)              overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (do_grant),
    .wr_data (wr_ev),
    .rd_en   (ev_valid && ev_ready),
    .rd_data (rd_ev),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign ev_valid = !fifo_empty;
  assign ev_key   = KW'(rd_ev.idx);
  assign ev_long  = rd_ev.long;
  assign pending  = pf_q | pl_q;
  assign overflow = overflow_q;

  full_matches_count: assert property (@(posedge clk) disable iff (rst)
    fifo_full == (32'(fifo_count) == FIFO_DEPTH));

endmodule

// File: tb/tb_key_event_arbiter.sv
module tb_key_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_first, key_long, pending;
  logic       ev_valid, ev_ready, ev_long, overflow, clr_overflow;
  logic [1:0] ev_key;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  key_event_arbiter #(
    .N_KEYS     (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_first    (key_first),
    .key_long     (key_long),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_key       (ev_key),
    .ev_long      (ev_long),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  typedef struct {
    logic       rst;
    logic [3:0] kf;
    logic [3:0] kl;
    logic       rdy;
    logic       clr;
    logic       valid;
    logic [1:0] key;
    logic       lng;
    logic [3:0] pend;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [1:0] key;
    logic       lng;
  } ev_t;

  vec_t vecs[$];
  ev_t  exp_q[$];

  function automatic vec_t v(input logic r, input logic [3:0] kf, input logic [3:0] kl,
                             input logic rdy, input logic clr, input logic valid,
                             input logic [1:0] key, input logic lng, input logic [3:0] pend,
                             input logic ovf);
    vec_t t;
    t.rst = r; t.kf = kf; t.kl = kl; t.rdy = rdy; t.clr = clr;
    t.valid = valid; t.key = key; t.lng = lng; t.pend = pend; t.ovf = ovf;
    return t;
  endfunction

  function automatic ev_t e(input logic [1:0] key, input logic lng);
    ev_t t;
    t.key = key; t.lng = lng;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic valid, input logic [1:0] key,
                         input logic lng, input logic [3:0] pend, input logic ovf);
    chk({tag, ".ev_valid"}, 32'(ev_valid), 32'(valid));
    chk({tag, ".ev_key"},   32'(ev_key),   32'(key));
    chk({tag, ".ev_long"},  32'(ev_long),  32'(lng));
    chk({tag, ".pending"},  32'(pending),  32'(pend));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; key_first = '0; key_long = '0; ev_ready = 1'b0; clr_overflow = 1'b0;

    // Single press, ordering, wrap, same-key long+short.
    vecs.push_back(v(0, 4'b0000, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0100, 4'b0000, 0, 0,  0, 0, 0, 4'b0100, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 0, 0,  1, 2, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0));
    vecs.push_back(v(1, 4'b0000, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 0, 0,  0, 0, 0, 4'b1111, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b1110, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b1100, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b1000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  1, 1, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  1, 2, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  1, 3, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b1111, 4'b0000, 0, 0,  0, 0, 0, 4'b1111, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b1110, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  1, 1, 0, 4'b1100, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  1, 2, 0, 4'b1000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  1, 3, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0010, 4'b0010, 0, 0,  0, 0, 0, 4'b0010, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 0, 0,  1, 1, 1, 4'b0010, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 0, 0,  1, 1, 1, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  1, 1, 0, 4'b0000, 0));
    vecs.push_back(v(0, 4'b0000, 4'b0000, 1, 0,  0, 0, 0, 4'b0000, 0));

    step; step;
    rst = 1'b0;
    chk_out("reset", 0, 0, 0, 4'b0000, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; key_first = vecs[i].kf; key_long = vecs[i].kl;
      ev_ready = vecs[i].rdy; clr_overflow = vecs[i].clr;
      step;
      chk_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].key, vecs[i].lng,
              vecs[i].pend, vecs[i].ovf);
    end
    rst = 1'b0; key_first = '0; key_long = '0; ev_ready = 1'b0; clr_overflow = 1'b0;

    // Fill FIFO, hold pending while full, lose one, then drain with refill.
    rst = 1'b1; step; rst = 1'b0;
    key_first = 4'b1111; step; key_first = '0;
    key_long  = 4'b1111; step; key_long  = '0;
    repeat (7) step;
    chk_out("full8", 1, 0, 0, 4'b0000, 0);
    key_first = 4'b1111; step; key_first = '0;
    chk_out("full_pend", 1, 0, 0, 4'b1111, 0);
    step;
    chk("full_hold.pending", 32'(pending), 32'hf);
    key_first = 4'b0001; step; key_first = '0;
    chk("loss.overflow", 32'(overflow), 32'h1);

    exp_q = '{e(0,0), e(1,1), e(2,1), e(3,1), e(0,1), e(1,0), e(2,0), e(3,0),
              e(0,0), e(1,0), e(2,0), e(3,0)};
    ev_ready = 1'b1;
    begin
      int got;
      got = 0;
      for (int c = 0; c < 40 && got < 12; c++) begin
        if (ev_valid) begin
          chk($sformatf("drain%0d.key", got), 32'(ev_key), 32'(exp_q[got].key));
          chk($sformatf("drain%0d.long", got), 32'(ev_long), 32'(exp_q[got].lng));
          got++;
        end
        step;
      end
      chk("drain.count", 32'(got), 32'd12);
    end
    step;
    chk_out("drained", 0, 0, 0, 4'b0000, 1);
    ev_ready = 1'b0;
    clr_overflow = 1'b1; step; clr_overflow = 1'b0;
    chk("clr.overflow", 32'(overflow), 32'h0);

    // Clear and loss in the same cycle: loss wins.
    key_first = 4'b0111; step;
    key_first = 4'b0100; step;
    chk("loss2.overflow", 32'(overflow), 32'h1);
    key_first = 4'b0100; clr_overflow = 1'b1; step;
    chk("clr_vs_loss.overflow", 32'(overflow), 32'h1);
    chk("clr_vs_loss.pending", 32'(pending), 32'h4);
    key_first = '0; step; clr_overflow = 1'b0;
    chk("clr_only.overflow", 32'(overflow), 32'h0);

    // Async reset mid-stream with 3 queued and 2 pending.
    rst = 1'b1; step; rst = 1'b0;
    key_long = 4'b1111; step;
    key_long = 4'b0010; step;
    key_long = 4'b0000; step;
    key_first = 4'b0001; step; key_first = '0;
    chk_out("pre_rst", 1, 0, 1, 4'b1001, 1);
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 0, 0, 0, 4'b0000, 0);
    step;
    rst = 1'b0;
    key_first = 4'b1000; step; key_first = '0;
    chk_out("post_rst1", 0, 0, 0, 4'b1000, 0);
    step;
    chk_out("post_rst2", 1, 3, 0, 4'b0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
